// File: rtl/universal_reg.sv
// WIDTH-bit general-purpose register: hold, load, shifts, rotates, increment
// and decrement, with a registered carry/shift-out flag and a combinational zero flag.
module universal_reg #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             Clear,
    input  logic [2:0]       Mode,
    input  logic             Ser_in,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Data_out,
    output logic             Carry_out,
    output logic             Zero
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

    localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    mode_e            mode;

    assign mode = mode_e'(Mode);

    always_comb begin
        data_d  = data_q;
        carry_d = carry_q;
        if (Clear) begin
            data_d  = RESET_VALUE;
            carry_d = 1'b0;
        end else if (En) begin
            case (mode)
                MODE_HOLD: begin
                    data_d  = data_q;
                    carry_d = carry_q;
                end
                MODE_LOAD: begin
                    data_d  = Data_in;
                    carry_d = 1'b0;
                end
                MODE_SHL: begin
                    data_d  = {data_q[WIDTH-2:0], Ser_in};
                    carry_d = data_q[WIDTH-1];
                end
                MODE_SHR: begin
                    data_d  = {Ser_in, data_q[WIDTH-1:1]};
                    carry_d = data_q[0];
                end
                MODE_ROL: begin
                    data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    carry_d = data_q[WIDTH-1];
                end
                MODE_ROR: begin
                    data_d  = {data_q[0], data_q[WIDTH-1:1]};
                    carry_d = data_q[0];
                end
                // Extended by one bit so the top bit is the carry (inc) or borrow (dec).
                MODE_INC: {carry_d, data_d} = {1'b0, data_q} + ONE_EXT;
                MODE_DEC: {carry_d, data_d} = {1'b0, data_q} - ONE_EXT;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            data_q  <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    assign Data_out  = data_q;
    assign Carry_out = carry_q;
    assign Zero      = (data_q == '0);

endmodule

// File: tb/tb_universal_reg.sv
// Bench for universal_reg: a 32-bit and an 8-bit instance share stimulus and are
// compared against an arithmetic reference model of the register.
module tb_universal_reg;

    logic        Clock;
    logic        Reset;
    logic        En;
    logic        Clear;
    logic [2:0]  Mode;
    logic        Ser_in;
    logic [31:0] Data_in;

    logic [31:0] d32_out;
    logic        c32_out, z32_out;
    logic [7:0]  d8_out;
    logic        c8_out, z8_out;

    logic [31:0] m32_d;
    logic        m32_c;
    logic [31:0] m8_d;
    logic        m8_c;

    int checks;
    int errors;

    universal_reg #(.WIDTH(32)) dut32 (
        .Clock(Clock), .Reset(Reset), .En(En), .Clear(Clear), .Mode(Mode),
        .Ser_in(Ser_in), .Data_in(Data_in),
        .Data_out(d32_out), .Carry_out(c32_out), .Zero(z32_out)
    );

    universal_reg #(.WIDTH(8)) dut8 (
        .Clock(Clock), .Reset(Reset), .En(En), .Clear(Clear), .Mode(Mode),
        .Ser_in(Ser_in), .Data_in(Data_in[7:0]),
        .Data_out(d8_out), .Carry_out(c8_out), .Zero(z8_out)
    );

    // clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model: register value as an unsigned number modulo 2^w.
    function automatic logic [32:0] model_next(int w, logic [31:0] d, logic c,
                                               logic en, logic clr, logic [2:0] mode,
                                               logic ser, logic [31:0] din);
        longint unsigned m, top, v, nd;
        logic nc;
        m   = 64'd1 << w;
        top = 64'd1 << (w - 1);
        v   = longint'(d);
        nd  = v;
        nc  = c;
        if (clr) begin
            nd = 0;
            nc = 1'b0;
        end else if (en) begin
            case (mode)
                3'd0: ;
                3'd1: begin nd = longint'(din) % m; nc = 1'b0; end
                3'd2: begin nd = (v * 2 + longint'(ser)) % m; nc = (v >= top); end
                3'd3: begin nd = v / 2 + longint'(ser) * top; nc = (v % 2) == 1; end
                3'd4: begin nd = (v * 2 + v / top) % m; nc = (v >= top); end
                3'd5: begin nd = v / 2 + (v % 2) * top; nc = (v % 2) == 1; end
                3'd6: begin nd = (v + 1) % m; nc = (v + 1) >= m; end
                3'd7: begin nd = (v + m - 1) % m; nc = (v == 0); end
            endcase
        end
        return {nc, nd[31:0]};
    endfunction

    // driver: apply one edge of stimulus, advance the model, settle 1 time unit past the edge
    task automatic apply(input logic en, input logic clr, input logic [2:0] mode,
                         input logic ser, input logic [31:0] din);
        logic [32:0] r;
        En = en; Clear = clr; Mode = mode; Ser_in = ser; Data_in = din;
        @(posedge Clock);
        r = model_next(32, m32_d, m32_c, en, clr, mode, ser, din);
        {m32_c, m32_d} = r;
        r = model_next(8, m8_d, m8_c, en, clr, mode, ser, din);
        {m8_c, m8_d} = r;
        #1;
    endtask

    task automatic model_reset();
        m32_d = 32'd0; m32_c = 1'b0;
        m8_d  = 32'd0; m8_c  = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; En = 1'b0; Clear = 1'b0; Mode = 3'd0; Ser_in = 1'b0;
        Data_in = 32'hDEADBEEF;
        model_reset();
        #13;
        checks++;
        if (d32_out !== 32'd0 || c32_out !== 1'b0 || z32_out !== 1'b1) begin
            errors++;
            $display("FAIL reset32: got d=%h c=%b z=%b, expected d=00000000 c=0 z=1", d32_out, c32_out, z32_out);
        end
        checks++;
        if (d8_out !== 8'd0 || c8_out !== 1'b0 || z8_out !== 1'b1) begin
            errors++;
            $display("FAIL reset8: got d=%h c=%b z=%b, expected d=00 c=0 z=1", d8_out, c8_out, z8_out);
        end
        @(negedge Clock);
        Reset = 1'b1;
        apply(1'b1, 1'b0, 3'd1, 1'b0, 32'hDEADBEEF);
        checks++;
        if (d32_out !== 32'hDEADBEEF || z32_out !== 1'b0 || c32_out !== 1'b0) begin
            errors++;
            $display("FAIL load32: got d=%h z=%b c=%b, expected d=deadbeef z=0 c=0", d32_out, z32_out, c32_out);
        end
        checks++;
        if (d8_out !== 8'hEF || z8_out !== 1'b0) begin
            errors++;
            $display("FAIL load8: got d=%h z=%b, expected d=ef z=0", d8_out, z8_out);
        end
    endtask

    task automatic test_enable();
        apply(1'b1, 1'b0, 3'd1, 1'b0, 32'd8);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 3'd6, 1'b0, 32'd0);
        checks++;
        if (d32_out !== 32'd8 || d8_out !== 8'd8) begin
            errors++;
            $display("FAIL enable_hold: got d32=%0d d8=%0d, expected 8", d32_out, d8_out);
        end
        for (int i = 0; i < 2; i++) apply(1'b1, 1'b0, 3'd6, 1'b0, 32'd0);
        checks++;
        if (d32_out !== 32'd10 || d8_out !== 8'd10) begin
            errors++;
            $display("FAIL enable_count: got d32=%0d d8=%0d, expected 10", d32_out, d8_out);
        end
    endtask

    task automatic test_shift_rotate();
        logic [7:0]  exp8  [4] = '{8'b0000_0010, 8'b1000_0001, 8'b1100_0000, 8'b1000_0001};
        logic        expc  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  modes [4] = '{3'd2, 3'd3, 3'd5, 3'd4};
        logic        sers  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        apply(1'b1, 1'b0, 3'd1, 1'b0, 32'h0000_0081);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, modes[i], sers[i], 32'd0);
            checks++;
            if (d8_out !== exp8[i] || c8_out !== expc[i]) begin
                errors++;
                $display("FAIL shift8_step%0d: got d=%b c=%b, expected d=%b c=%b", i, d8_out, c8_out, exp8[i], expc[i]);
            end
            checks++;
            if (d32_out !== m32_d || c32_out !== m32_c) begin
                errors++;
                $display("FAIL shift32_step%0d: got d=%h c=%b, expected d=%h c=%b", i, d32_out, c32_out, m32_d, m32_c);
            end
        end
    endtask

    task automatic test_count_wrap();
        apply(1'b1, 1'b0, 3'd1, 1'b0, 32'hFFFF_FFFF);
        apply(1'b1, 1'b0, 3'd6, 1'b0, 32'd0);
        checks++;
        if (d8_out !== 8'h00 || c8_out !== 1'b1 || z8_out !== 1'b1 ||
            d32_out !== 32'd0 || c32_out !== 1'b1 || z32_out !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap: got d8=%h c8=%b z8=%b d32=%h c32=%b z32=%b, expected 0/1/1", d8_out, c8_out, z8_out, d32_out, c32_out, z32_out);
        end
        apply(1'b1, 1'b0, 3'd7, 1'b0, 32'd0);
        checks++;
        if (d8_out !== 8'hFF || c8_out !== 1'b1 || d32_out !== 32'hFFFF_FFFF || c32_out !== 1'b1) begin
            errors++;
            $display("FAIL dec_wrap: got d8=%h c8=%b d32=%h c32=%b, expected all-ones c=1", d8_out, c8_out, d32_out, c32_out);
        end
        apply(1'b1, 1'b0, 3'd7, 1'b0, 32'd0);
        checks++;
        if (d8_out !== 8'hFE || c8_out !== 1'b0 || d32_out !== 32'hFFFF_FFFE || c32_out !== 1'b0) begin
            errors++;
            $display("FAIL dec_plain: got d8=%h c8=%b d32=%h c32=%b, expected fe/fffffffe c=0", d8_out, c8_out, d32_out, c32_out);
        end
    endtask

    task automatic test_clear();
        apply(1'b1, 1'b0, 3'd1, 1'b0, 32'd16);
        apply(1'b1, 1'b1, 3'd1, 1'b0, 32'd5);
        checks++;
        if (d32_out !== 32'd0 || c32_out !== 1'b0 || d8_out !== 8'd0) begin
            errors++;
            $display("FAIL clear_en: got d32=%h c32=%b d8=%h, expected 0", d32_out, c32_out, d8_out);
        end
        apply(1'b1, 1'b0, 3'd1, 1'b0, 32'hFFFF_FFFF);
        apply(1'b1, 1'b0, 3'd2, 1'b1, 32'd0);
        apply(1'b0, 1'b1, 3'd6, 1'b0, 32'd0);
        checks++;
        if (d32_out !== 32'd0 || c32_out !== 1'b0 || d8_out !== 8'd0 || c8_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_en: got d32=%h c32=%b d8=%h c8=%b, expected 0", d32_out, c32_out, d8_out, c8_out);
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 1'b1, 3'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 3'd6, 1'b0, 32'd0);
        checks++;
        if (d32_out !== 32'd3 || d8_out !== 8'd3) begin
            errors++;
            $display("FAIL count3: got d32=%0d d8=%0d, expected 3", d32_out, d8_out);
        end
        #4;
        Reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (d32_out !== 32'd0 || z32_out !== 1'b1 || c32_out !== 1'b0 || d8_out !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got d32=%h z32=%b c32=%b d8=%h, expected 0/1/0/0", d32_out, z32_out, c32_out, d8_out);
        end
        #2;
        Reset = 1'b1;
        apply(1'b1, 1'b0, 3'd6, 1'b0, 32'd0);
        checks++;
        if (d32_out !== 32'd1 || d8_out !== 8'd1) begin
            errors++;
            $display("FAIL resume: got d32=%0d d8=%0d, expected 1", d32_out, d8_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom());
            checks++;
            if (d32_out !== m32_d || c32_out !== m32_c || z32_out !== (m32_d == 32'd0)) begin
                errors++;
                $display("FAIL random32 #%0d: got d=%h c=%b z=%b, expected d=%h c=%b", i, d32_out, c32_out, z32_out, m32_d, m32_c);
            end
            checks++;
            if (d8_out !== m8_d[7:0] || c8_out !== m8_c || z8_out !== (m8_d[7:0] == 8'd0)) begin
                errors++;
                $display("FAIL random8 #%0d: got d=%h c=%b z=%b, expected d=%h c=%b", i, d8_out, c8_out, z8_out, m8_d[7:0], m8_c);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_enable();
        test_shift_rotate();
        test_count_wrap();
        test_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_reg.md
# universal_reg

Parametrised successor to the team's 32-bit enabled register: a WIDTH-bit register with eight operating modes (hold, parallel load, logical shifts, rotates, increment, decrement). It also provides a registered carry/shift-out flag and a zero flag. It is the general-purpose register for the datapath experiments (accumulator, shift register, program/loop counter) and replaces the plain load-only register.

## Interface
- WIDTH, 32, data width in bits; legal range ≥ 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Data_out on Reset and on Clear.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- En  input  1  operation enable; 0 = hold everything.
- Clear  input  1  synchronous clear; active-high.
- Mode  input  3  operation select; see Operation.
- Ser_in  input  1  serial fill bit for logical shifts.
- Data_in  input  WIDTH  parallel load value.
- Data_out  output  WIDTH  register contents.
- Carry_out  output  1  registered carry, borrow, or shifted-out bit of the last executed operation.
- Zero  output  1  combinational: 1 when Data_out == 0.

## Operation
- Priority, highest first: Reset (async) > Clear > En.
- Reset low: Data_out = RESET_VALUE and Carry_out = 0 immediately, independent of Clock. Zero follows Data_out.
- Clear = 1 at an edge: Data_out = RESET_VALUE and Carry_out = 0, regardless of En and Mode.
- En = 0 and Clear = 0 at an edge: Data_out and Carry_out hold.
- En = 1 and Clear = 0 at an edge: execute Mode. "D" is the current Data_out. Only one bit moves per shift or rotate.
  - 000 hold: D and Carry_out unchanged.
  - 001 load: D ← Data_in; Carry_out ← 0.
  - 010 shift left: D ← {D[WIDTH-2:0], Ser_in}; Carry_out ← D[WIDTH-1].
  - 011 shift right: D ← {Ser_in, D[WIDTH-1:1]}; Carry_out ← D[0].
  - 100 rotate left: D ← {D[WIDTH-2:0], D[WIDTH-1]}; Carry_out ← D[WIDTH-1].
  - 101 rotate right: D ← {D[0], D[WIDTH-1:1]}; Carry_out ← D[0].
  - 110 increment: {Carry_out, D} ← D + 1, computed at WIDTH+1 bits. All-ones wraps to 0 with Carry_out = 1; otherwise Carry_out = 0.
  - 111 decrement: D ← D − 1, modulo 2^WIDTH. Carry_out = 1 (borrow) only when D was 0, which wraps to all-ones.
- Arithmetic is unsigned modulo 2^WIDTH. No saturation.
- No X propagation from Ser_in is required when Mode does not use it.

## Timing
- All state changes occur on the rising Clock edge. The exception is Reset assertion, which acts immediately.
- Latency is 1 cycle: the result of the operation sampled at edge n is visible on Data_out and Carry_out after edge n.
- Zero is combinational from Data_out, so it is valid in the same cycle as Data_out, with no additional latency.
- Reset deassertion is synchronised externally. The first operation executes on the first rising edge with Reset high.
- Reset asserted mid-operation, such as during a count or shift sequence, aborts it. No partial state survives.
- The register supports back-to-back operations every cycle. Mode may change on every cycle.

## Test plan
- Reset and load: hold Reset low with Data_in = 32'hDEADBEEF, then release Reset. Expect Data_out = 0, Zero = 1, Carry_out = 0. Apply Mode = 001 with En = 1 for one edge. Expect Data_out = 32'hDEADBEEF, Zero = 0.
- Enable gating: load 32'd8, then set En = 0 with Mode = 110 for 3 edges. Expect Data_out to stay 8. Set En = 1 for 2 edges. Expect Data_out = 10.
- Shifts and rotates, WIDTH = 8: load 8'b1000_0001.
  - Shift left with Ser_in = 0: Data_out = 8'b0000_0010, Carry_out = 1.
  - Then shift right with Ser_in = 1: Data_out = 8'b1000_0001, Carry_out = 0.
  - Then rotate right: Data_out = 8'b1100_0000, Carry_out = 1.
  - Then rotate left: Data_out = 8'b1000_0001, Carry_out = 1.
- Count wrap, WIDTH = 8:
  - Load 8'hFF, then increment: Data_out = 0, Carry_out = 1, Zero = 1.
  - Decrement: Data_out = 8'hFF, Carry_out = 1.
  - Decrement: Data_out = 8'hFE, Carry_out = 0.
- Clear priority: load 32'd16, then assert Clear = 1 with En = 1 and Mode = 001 (Data_in = 5) on the same edge. Expect Data_out = 0 and Carry_out = 0. Then assert Clear with En = 0. Expect the clear still takes effect.
- Async reset mid-count: increment from 0. Pull Reset low midway between edges after the 3rd edge. Expect Data_out = 0 within the same cycle, before the next edge. After release, the increment resumes from 0.
